// File: rtl/pipe_hazard_unit_pkg.sv
// pipe_hazard_unit_pkg: shared encodings for the pipeline hazard unit.
// Forward-select codes, memory-wait FSM states and the x0 register index.
package pipe_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_X0 = 0;

  // wait counter width covers MEM_TIMEOUT up to 2^16-1
  localparam int WCNT_W = 16;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mw_state_e;

endpackage

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// pipe_hazard_unit_fwd_sel: operand forward select for one EX source.
// Ports: rs, mem_rd/mem_reg_write, wb_rd/wb_reg_write in; sel out.
module pipe_hazard_unit_fwd_sel
  import pipe_hazard_unit_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] rs,
  input  logic [W-1:0] mem_rd,
  input  logic         mem_reg_write,
  input  logic [W-1:0] wb_rd,
  input  logic         wb_reg_write,
  output logic [1:0]   sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write
                 && (mem_rd != W'(REG_X0))
                 && (mem_rd == rs);
  assign wb_hit  = wb_reg_write
                 && (wb_rd != W'(REG_X0))
                 && (wb_rd == rs);

  // MEM holds the younger result, so it wins
  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      mem_hit:           sel = FWD_MEM;
      wb_hit && !mem_hit: sel = FWD_WB;
      default:           sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: forwarding, load-use, mem-wait and branch-flush control.
// Ports: ID/EX/MEM/WB register info, mem_req/mem_ready, branch_taken in;
//   fwd_1/fwd_2, holds, bubbles, flushes, mem_err, perf_stall/perf_flush out.
// Optional counters: define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  branch_taken,
  output logic [1:0]            fwd_1,
  output logic [1:0]            fwd_2,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  id_ex_hold,
  output logic                  ex_mem_hold,
  output logic                  id_ex_bubble,
  output logic                  mem_wb_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_err,
  output logic [PERF_W-1:0]     perf_stall,
  output logic [PERF_W-1:0]     perf_flush
);

  mw_state_e         state;
  logic [WCNT_W-1:0] wcnt;
  logic              lu;
  logic              mw;
  logic              tmo;
  logic              br;

  pipe_hazard_unit_fwd_sel #(.W(REG_ADDR_W)) u_fwd_1 (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_1)
  );

  pipe_hazard_unit_fwd_sel #(.W(REG_ADDR_W)) u_fwd_2 (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_2)
  );

  always_comb begin
    lu = ex_mem_read
      && (ex_rd != REG_ADDR_W'(REG_X0))
      && ((id_rs1_used && (id_rs1 == ex_rd))
       || (id_rs2_used && (id_rs2 == ex_rd)));
    // last permitted WAIT cycle: give up and release
    tmo = (state == ST_WAIT) && !mem_ready
       && (wcnt == WCNT_W'(MEM_TIMEOUT));
    mw = ((state == ST_IDLE) && mem_req && !mem_ready)
      || ((state == ST_WAIT) && !mem_ready && !tmo);
    br = branch_taken && !mw;
  end

  always_comb begin
    pc_hold       = mw || (lu && !br);
    if_id_hold    = mw || (lu && !br);
    id_ex_hold    = mw;
    ex_mem_hold   = mw;
    mem_wb_bubble = mw;
    id_ex_bubble  = lu && !mw;
    if_id_flush   = br;
    id_ex_flush   = br;
    ex_mem_flush  = br;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mem_req && !mem_ready) begin
            state <= ST_WAIT;
            wcnt  <= WCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            state <= ST_IDLE;
            wcnt  <= '0;
          end else if (tmo) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (br && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed bench with a rule-level reference model.
// Checks every cycle plus literal expectations along the directed sequence.
module tb_pipe_hazard_unit;

  localparam int AW   = 5;
  localparam int TMO  = 4;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_rs1_used, id_rs2_used, ex_mem_read;
  logic          mem_reg_write, mem_req, mem_ready;
  logic          wb_reg_write, branch_taken;
  logic [1:0]    fwd_1, fwd_2;
  logic          pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic          id_ex_bubble, mem_wb_bubble;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
  logic [PW-1:0] perf_stall, perf_flush;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // model state: waiting flag, index of the current WAIT cycle, sticky error
  bit m_wait = 1'b0;
  int m_n    = 0;
  bit m_err  = 1'b0;
  int m_ps   = 0;
  int m_pf   = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .REG_ADDR_W  (AW),
    .MEM_TIMEOUT (TMO),
    .PERF_W      (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .branch_taken  (branch_taken),
    .fwd_1         (fwd_1),
    .fwd_2         (fwd_2),
    .pc_hold       (pc_hold),
    .if_id_hold    (if_id_hold),
    .id_ex_hold    (id_ex_hold),
    .ex_mem_hold   (ex_mem_hold),
    .id_ex_bubble  (id_ex_bubble),
    .mem_wb_bubble (mem_wb_bubble),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .mem_err       (mem_err),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_exp(logic [AW-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 1;
    return 0;
  endfunction

  function automatic bit e_lu();
    if (!ex_mem_read || ex_rd == 0) return 1'b0;
    return (id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd);
  endfunction

  function automatic bit e_timeout();
    return m_wait && !mem_ready && m_n == TMO;
  endfunction

  function automatic bit e_mw();
    if (m_wait) return !mem_ready && !e_timeout();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit e_br();
    return branch_taken && !e_mw();
  endfunction

  function automatic bit e_pch();
    return e_mw() || (e_lu() && !e_br());
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_wait = 1'b0;
      m_n    = 0;
      m_err  = 1'b0;
      m_ps   = 0;
      m_pf   = 0;
    end else begin
      if (e_pch() && m_ps < PMAX) m_ps = m_ps + 1;
      if (e_br() && m_pf < PMAX) m_pf = m_pf + 1;
      if (m_wait) begin
        if (mem_ready) begin
          m_wait = 1'b0;
        end else if (e_timeout()) begin
          m_wait = 1'b0;
          m_err  = 1'b1;
        end else begin
          m_n = m_n + 1;
        end
      end else if (mem_req && !mem_ready) begin
        m_wait = 1'b1;
        m_n    = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_fwd_1", int'(fwd_1), fwd_exp(ex_rs1));
      chk("m_fwd_2", int'(fwd_2), fwd_exp(ex_rs2));
      chk("m_pc_hold", int'(pc_hold), int'(e_pch()));
      chk("m_if_id_hold", int'(if_id_hold), int'(e_pch()));
      chk("m_id_ex_hold", int'(id_ex_hold), int'(e_mw()));
      chk("m_ex_mem_hold", int'(ex_mem_hold), int'(e_mw()));
      chk("m_mem_wb_bubble", int'(mem_wb_bubble), int'(e_mw()));
      chk("m_id_ex_bubble", int'(id_ex_bubble), int'(e_lu() && !e_mw()));
      chk("m_if_id_flush", int'(if_id_flush), int'(e_br()));
      chk("m_id_ex_flush", int'(id_ex_flush), int'(e_br()));
      chk("m_ex_mem_flush", int'(ex_mem_flush), int'(e_br()));
      chk("m_mem_err", int'(mem_err), int'(m_err));
      chk("m_perf_stall", int'(perf_stall), PERF_ON ? m_ps : 0);
      chk("m_perf_flush", int'(perf_flush), PERF_ON ? m_pf : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_mem_read, mem_reg_write} = '0;
    {mem_req, mem_ready, wb_reg_write, branch_taken} = '0;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_pc_hold", int'(pc_hold), 0);
    chk("rst_mem_err", int'(mem_err), 0);
    chk("rst_perf_stall", int'(perf_stall), 0);
    tick();
    rst = 1'b0;

    // forwarding priority and x0
    mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
    ex_rs1 = 5; ex_rs2 = 5;
    @(negedge clk);
    chk("fwd_mem", int'(fwd_1), 2);
    chk("fwd_mem_2", int'(fwd_2), 2);
    tick();
    mem_reg_write = 0;
    @(negedge clk);
    chk("fwd_wb", int'(fwd_1), 1);
    tick();
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
    @(negedge clk);
    chk("fwd_x0", int'(fwd_1), 0);
    tick();
    quiet();

    // load-use, then the bubble has moved on
    ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_rs2_used = 1;
    @(negedge clk);
    chk("lu_pc_hold", int'(pc_hold), 1);
    chk("lu_if_id_hold", int'(if_id_hold), 1);
    chk("lu_bubble", int'(id_ex_bubble), 1);
    chk("lu_id_ex_hold", int'(id_ex_hold), 0);
    tick();
    ex_mem_read = 0;
    @(negedge clk);
    chk("lu_gone", int'(pc_hold), 0);
    tick();
    ex_mem_read = 1; id_rs2_used = 0;
    @(negedge clk);
    chk("lu_unused", int'(pc_hold), 0);
    chk("lu_unused_bub", int'(id_ex_bubble), 0);
    tick();
    quiet();

    // ready ignored without a request
    mem_ready = 1;
    @(negedge clk);
    chk("rdy_noreq", int'(ex_mem_hold), 0);
    tick();
    mem_ready = 0;
    @(negedge clk);
    chk("rdy_noreq_2", int'(pc_hold), 0);
    tick();

    // three wait cycles then ready
    mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_hold", int'(ex_mem_hold), 1);
      chk("mw_bubble", int'(mem_wb_bubble), 1);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("mw_release", int'(ex_mem_hold), 0);
    chk("mw_release_pc", int'(pc_hold), 0);
    chk("mw_no_err", int'(mem_err), 0);
    tick();
    quiet();
    tick();

    // timeout after four WAIT cycles
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_hold", int'(pc_hold), 1);
      tick();
    end
    @(negedge clk);
    chk("to_release", int'(pc_hold), 0);
    chk("to_err_pre", int'(mem_err), 0);
    tick();
    mem_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_err_sticky", int'(mem_err), 1);
      tick();
    end

    // branch overrides load-use
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
    branch_taken = 1;
    @(negedge clk);
    chk("br_if_id_flush", int'(if_id_flush), 1);
    chk("br_id_ex_flush", int'(id_ex_flush), 1);
    chk("br_ex_mem_flush", int'(ex_mem_flush), 1);
    chk("br_pc_hold", int'(pc_hold), 0);
    chk("br_bubble", int'(id_ex_bubble), 1);
    tick();
    quiet();

    // branch deferred while waiting on memory
    mem_req = 1; branch_taken = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("br_defer", int'(if_id_flush), 0);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("br_after_rdy", int'(ex_mem_flush), 1);
    tick();
    quiet();

    // reset in the middle of a wait
    mem_req = 1;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; mem_req = 0;
    @(negedge clk);
    chk("rst_wait_hold", int'(pc_hold), 0);
    chk("rst_wait_err", int'(mem_err), 0);
    tick();

    // twenty stall cycles saturate a 4-bit counter
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
    repeat (20) tick();
    quiet();
    @(negedge clk);
    chk("perf_sat", int'(perf_stall), PERF_ON ? 15 : 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("perf_clr", int'(perf_stall), 0);
    tick();
    tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
